// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial RAM arbiter: size codes, FSM states,
// transaction owners and the size-to-byte-count mapping.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Reserved size code 3 is handled as a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and byte-wide RAM signals of the arbiter, bundled as one interface.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_done_o;
    logic              mem_req_i;
    logic              mem_wr_i;
    logic [1:0]        mem_size_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_done_o;
    logic [7:0]        ram_din_i;
    logic [7:0]        ram_dout_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_wr_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
        output ram_dout_o, ram_a_o, ram_wr_o, busy_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_wr_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
        input  ram_dout_o, ram_a_o, ram_wr_o, busy_o
    );
endinterface

// File: rtl/mem_byte_assembler.sv
// Collects RAM read bytes into a little-endian word; byte idx lands in bits [8*idx+7:8*idx].
module mem_byte_assembler #(
    parameter  int DATA_W = 32,
    localparam int IDX_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [7:0]        din,
    output logic [DATA_W-1:0] word
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
        end else if (clr) begin
            word <= '0;
        end else if (we) begin
            word[{idx, 3'b000} +: 8] <= din;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter: MEM stage has fixed priority over instruction fetch,
// every access is split into little-endian byte cycles and finished with a done pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    localparam int IDX_W = $clog2(DATA_W / 8);

    state_t            state, state_d;
    owner_t            own, own_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [DATA_W-1:0] wdata, wdata_d;
    logic [2:0]        n, n_d;
    logic [2:0]        step, step_d;
    logic [ADDR_W-1:0] ram_a, ram_a_d;
    logic [7:0]        ram_dout, ram_dout_d;
    logic              ram_wr, ram_wr_d;
    logic              asm_clr, asm_we;
    logic [IDX_W-1:0]  asm_idx;
    logic [DATA_W-1:0] asm_word;
    logic [7:0]        wbyte;

    // step counts edges since accept; byte (step-2) arrives from the sync RAM at edge step.
    assign asm_idx = IDX_W'(step - 3'd2);
    assign wbyte   = wdata[{step[IDX_W-1:0], 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            own      <= OWN_IF;
            addr     <= '0;
            wdata    <= '0;
            n        <= '0;
            step     <= '0;
            ram_a    <= '0;
            ram_dout <= '0;
            ram_wr   <= 1'b0;
        end else begin
            state    <= state_d;
            own      <= own_d;
            addr     <= addr_d;
            wdata    <= wdata_d;
            n        <= n_d;
            step     <= step_d;
            ram_a    <= ram_a_d;
            ram_dout <= ram_dout_d;
            ram_wr   <= ram_wr_d;
        end
    end

    always_comb begin
        state_d    = state;
        own_d      = own;
        addr_d     = addr;
        wdata_d    = wdata;
        n_d        = n;
        step_d     = step;
        ram_a_d    = ram_a;
        ram_dout_d = ram_dout;
        ram_wr_d   = ram_wr;
        asm_clr    = 1'b0;
        asm_we     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.mem_req_i) begin
                    own_d   = OWN_MEM;
                    addr_d  = bus.mem_addr_i;
                    wdata_d = bus.mem_wdata_i;
                    n_d     = byte_count(bus.mem_size_i);
                    step_d  = 3'd1;
                    ram_a_d = bus.mem_addr_i;
                    asm_clr = 1'b1;
                    if (bus.mem_wr_i) begin
                        state_d    = ST_WRITE;
                        ram_dout_d = bus.mem_wdata_i[7:0];
                        ram_wr_d   = 1'b1;
                    end else begin
                        state_d  = ST_READ;
                        ram_wr_d = 1'b0;
                    end
                end else if (bus.if_req_i && !bus.if_flush_i) begin
                    state_d  = ST_READ;
                    own_d    = OWN_IF;
                    addr_d   = bus.if_addr_i;
                    wdata_d  = '0;
                    n_d      = 3'd4;
                    step_d   = 3'd1;
                    ram_a_d  = bus.if_addr_i;
                    ram_wr_d = 1'b0;
                    asm_clr  = 1'b1;
                end
            end
            ST_READ: begin
                if (own == OWN_IF && bus.if_flush_i) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    ram_a_d = '0;
                end else begin
                    ram_a_d = (step < n) ? addr + ADDR_W'(step) : '0;
                    asm_we  = (step >= 3'd2);
                    if (step == n + 3'd1) begin
                        state_d = ST_DONE;
                    end
                    step_d = step + 3'd1;
                end
            end
            ST_WRITE: begin
                if (step < n) begin
                    ram_a_d    = addr + ADDR_W'(step);
                    ram_dout_d = wbyte;
                    ram_wr_d   = 1'b1;
                end else begin
                    ram_a_d    = '0;
                    ram_dout_d = '0;
                    ram_wr_d   = 1'b0;
                    state_d    = ST_DONE;
                end
                step_d = step + 3'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_byte_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk  (clk),
        .rst  (rst),
        .clr  (asm_clr),
        .we   (asm_we),
        .idx  (asm_idx),
        .din  (bus.ram_din_i),
        .word (asm_word)
    );

    // A flush arriving during the fetch's DONE cycle suppresses the pulse without delay.
    assign bus.if_done_o   = (state == ST_DONE) && (own == OWN_IF) && !bus.if_flush_i;
    assign bus.mem_done_o  = (state == ST_DONE) && (own == OWN_MEM);
    assign bus.if_data_o   = asm_word;
    assign bus.mem_rdata_o = asm_word;
    assign bus.ram_a_o     = ram_a;
    assign bus.ram_dout_o  = ram_dout;
    assign bus.ram_wr_o    = ram_wr;
    assign bus.busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram [0:65535];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync RAM: read data appears one cycle after the address edge.
    always @(posedge clk) begin
        bus.ram_din_i <= ram[bus.ram_a_o[15:0]];
        if (bus.ram_wr_o) ram[bus.ram_a_o[15:0]] = bus.ram_dout_o;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0h expected 0", bus.busy_o); end
        checks++; if (bus.ram_wr_o !== 1'b0) begin failures++; $display("FAIL rst_wr: got %0h expected 0", bus.ram_wr_o); end
        checks++; if (bus.ram_a_o !== 32'h0) begin failures++; $display("FAIL rst_a: got %0h expected 0", bus.ram_a_o); end
        checks++; if (bus.ram_dout_o !== 8'h0) begin failures++; $display("FAIL rst_dout: got %0h expected 0", bus.ram_dout_o); end
        checks++; if ({bus.if_done_o, bus.mem_done_o} !== 2'b00) begin failures++; $display("FAIL rst_done: got %0b expected 00", {bus.if_done_o, bus.mem_done_o}); end
        checks++; if (bus.mem_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %0h expected 0", bus.mem_rdata_o); end
        checks++; if (bus.if_data_o !== 32'h0) begin failures++; $display("FAIL rst_ifdata: got %0h expected 0", bus.if_data_o); end
        bus.if_req_i = 1'b1;
        tick;
        tick;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_held_busy: got %0h expected 0", bus.busy_o); end
        bus.if_req_i = 1'b0;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_if_read;
        int cyc;
        ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
        bus.if_addr_i = 32'h100;
        bus.if_req_i  = 1'b1;
        tick;
        checks++; if (bus.ram_a_o !== 32'h100) begin failures++; $display("FAIL if_a0: got %0h expected 100", bus.ram_a_o); end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL if_busy: got %0h expected 1", bus.busy_o); end
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (i <= 3) begin
                checks++; if (bus.ram_a_o !== 32'h100 + 32'(i)) begin failures++; $display("FAIL if_a%0d: got %0h expected %0h", i, bus.ram_a_o, 32'h100 + 32'(i)); end
            end
            if (i == 4) begin
                checks++; if (bus.ram_a_o !== 32'h0) begin failures++; $display("FAIL if_a_ret: got %0h expected 0", bus.ram_a_o); end
            end
            if (bus.if_done_o === 1'b1) begin cyc = i; break; end
        end
        checks++; if (cyc !== 5) begin failures++; $display("FAIL if_latency: got %0d expected 5", cyc); end
        checks++; if (bus.if_data_o !== 32'h44332211) begin failures++; $display("FAIL if_data: got %0h expected 44332211", bus.if_data_o); end
        bus.if_req_i = 1'b0;
        tick;
        checks++; if ({bus.if_done_o, bus.busy_o} !== 2'b00) begin failures++; $display("FAIL if_done_len: got %0b expected 00", {bus.if_done_o, bus.busy_o}); end
    endtask

    task automatic test_store_load;
        logic [7:0] eb [4];
        int cyc;
        eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        bus.mem_wr_i = 1'b1; bus.mem_size_i = 2'd2; bus.mem_addr_i = 32'h2000; bus.mem_wdata_i = 32'hDEADBEEF;
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o} !== {1'b1, 32'h2000 + 32'(i), eb[i]})
                begin failures++; $display("FAIL sw_byte%0d: got wr=%0h a=%0h d=%0h expected wr=1 a=%0h d=%0h", i, bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o, 32'h2000 + 32'(i), eb[i]); end
        end
        tick;
        checks++; if (bus.mem_done_o !== 1'b1) begin failures++; $display("FAIL sw_done: got %0h expected 1", bus.mem_done_o); end
        checks++; if ({bus.ram_wr_o, bus.ram_a_o} !== 33'h0) begin failures++; $display("FAIL sw_end: got wr=%0h a=%0h expected 0", bus.ram_wr_o, bus.ram_a_o); end
        bus.mem_req_i = 1'b0;
        tick;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL sw_idle: got %0h expected 0", bus.busy_o); end
        bus.mem_wr_i = 1'b0;
        bus.mem_req_i = 1'b1;
        tick;
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (bus.mem_done_o === 1'b1) begin cyc = i; break; end
        end
        checks++; if (cyc !== 5) begin failures++; $display("FAIL lw_latency: got %0d expected 5", cyc); end
        checks++; if (bus.mem_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: got %0h expected deadbeef", bus.mem_rdata_o); end
        bus.mem_req_i = 1'b0;
        tick;
    endtask

    task automatic test_priority;
        int cyc;
        ram[16'h0010] = 8'h80;
        bus.if_addr_i = 32'h100; bus.if_req_i = 1'b1;
        bus.mem_wr_i = 1'b0; bus.mem_size_i = 2'd0; bus.mem_addr_i = 32'h10; bus.mem_req_i = 1'b1;
        tick;
        checks++; if (bus.ram_a_o !== 32'h10) begin failures++; $display("FAIL prio_a: got %0h expected 10", bus.ram_a_o); end
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (bus.mem_done_o === 1'b1) begin cyc = i; break; end
        end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL lb_latency: got %0d expected 2", cyc); end
        checks++; if (bus.mem_rdata_o !== 32'h00000080) begin failures++; $display("FAIL lb_data: got %0h expected 80", bus.mem_rdata_o); end
        checks++; if (bus.if_done_o !== 1'b0) begin failures++; $display("FAIL prio_ifdone: got %0h expected 0", bus.if_done_o); end
        bus.mem_req_i = 1'b0;
        tick;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL prio_gap: got %0h expected 0", bus.busy_o); end
        tick;
        checks++; if ({bus.busy_o, bus.ram_a_o} !== {1'b1, 32'h100}) begin failures++; $display("FAIL prio_if_acc: got busy=%0h a=%0h expected busy=1 a=100", bus.busy_o, bus.ram_a_o); end
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (bus.if_done_o === 1'b1) begin cyc = i; break; end
        end
        checks++; if (cyc !== 5) begin failures++; $display("FAIL prio_if_latency: got %0d expected 5", cyc); end
        checks++; if (bus.if_data_o !== 32'h44332211) begin failures++; $display("FAIL prio_if_data: got %0h expected 44332211", bus.if_data_o); end
        bus.if_req_i = 1'b0;
        tick;
    endtask

    task automatic test_flush;
        bus.if_addr_i = 32'h100; bus.if_req_i = 1'b1;
        tick;
        tick;
        checks++; if (bus.ram_a_o !== 32'h101) begin failures++; $display("FAIL fl_a1: got %0h expected 101", bus.ram_a_o); end
        bus.if_flush_i = 1'b1;
        tick;
        checks++; if ({bus.busy_o, bus.ram_a_o, bus.if_done_o} !== 34'h0) begin failures++; $display("FAIL fl_abort: got busy=%0h a=%0h done=%0h expected 0", bus.busy_o, bus.ram_a_o, bus.if_done_o); end
        bus.if_req_i = 1'b0;
        bus.mem_wr_i = 1'b1; bus.mem_size_i = 2'd1; bus.mem_addr_i = 32'h40; bus.mem_wdata_i = 32'h0000CAFE;
        bus.mem_req_i = 1'b1;
        tick;
        checks++; if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o} !== {1'b1, 32'h40, 8'hFE}) begin failures++; $display("FAIL sh_b0: got wr=%0h a=%0h d=%0h expected wr=1 a=40 d=fe", bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o); end
        tick;
        checks++; if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o} !== {1'b1, 32'h41, 8'hCA}) begin failures++; $display("FAIL sh_b1: got wr=%0h a=%0h d=%0h expected wr=1 a=41 d=ca", bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o); end
        tick;
        checks++; if ({bus.mem_done_o, bus.ram_wr_o, bus.if_done_o} !== 3'b100) begin failures++; $display("FAIL sh_done: got %0b expected 100", {bus.mem_done_o, bus.ram_wr_o, bus.if_done_o}); end
        bus.mem_req_i = 1'b0; bus.if_flush_i = 1'b0;
        tick;
        bus.if_req_i = 1'b1;
        tick;
        repeat (5) tick;
        bus.if_flush_i = 1'b1;
        #1;
        checks++; if (bus.if_done_o !== 1'b0) begin failures++; $display("FAIL fl_gate: got %0h expected 0", bus.if_done_o); end
        bus.if_flush_i = 1'b0;
        #1;
        checks++; if (bus.if_done_o !== 1'b1) begin failures++; $display("FAIL fl_ungate: got %0h expected 1", bus.if_done_o); end
        bus.if_req_i = 1'b0;
        tick;
    endtask

    task automatic test_size3;
        logic [7:0] eb [4];
        eb = '{8'h04, 8'h03, 8'h02, 8'h01};
        bus.mem_wr_i = 1'b1; bus.mem_size_i = 2'd3; bus.mem_addr_i = 32'h300; bus.mem_wdata_i = 32'h01020304;
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o} !== {1'b1, 32'h300 + 32'(i), eb[i]})
                begin failures++; $display("FAIL sz3_byte%0d: got wr=%0h a=%0h d=%0h expected wr=1 a=%0h d=%0h", i, bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o, 32'h300 + 32'(i), eb[i]); end
        end
        tick;
        checks++; if ({bus.mem_done_o, bus.ram_wr_o} !== 2'b10) begin failures++; $display("FAIL sz3_done: got %0b expected 10", {bus.mem_done_o, bus.ram_wr_o}); end
        bus.mem_req_i = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int cyc;
        bus.mem_wr_i = 1'b1; bus.mem_size_i = 2'd2; bus.mem_addr_i = 32'h2000; bus.mem_wdata_i = 32'h12345678;
        bus.mem_req_i = 1'b1;
        tick;
        tick;
        checks++; if ({bus.ram_wr_o, bus.ram_dout_o} !== {1'b1, 8'h56}) begin failures++; $display("FAIL rm_pre: got wr=%0h d=%0h expected wr=1 d=56", bus.ram_wr_o, bus.ram_dout_o); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o, bus.busy_o} !== 42'h0) begin failures++; $display("FAIL rm_async: got wr=%0h a=%0h d=%0h busy=%0h expected 0", bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o, bus.busy_o); end
        checks++; if ({bus.mem_done_o, bus.mem_rdata_o} !== 33'h0) begin failures++; $display("FAIL rm_outs: got done=%0h rdata=%0h expected 0", bus.mem_done_o, bus.mem_rdata_o); end
        tick;
        tick;
        checks++; if ({bus.ram_wr_o, bus.busy_o} !== 2'b00) begin failures++; $display("FAIL rm_held: got %0b expected 00", {bus.ram_wr_o, bus.busy_o}); end
        bus.mem_req_i = 1'b0;
        rst = 1'b1;
        tick;
        ram[16'hFFFF] = 8'hA5;
        ram[16'h0000] = 8'h5A;
        bus.mem_wr_i = 1'b0; bus.mem_size_i = 2'd1; bus.mem_addr_i = 32'h3FFFFFFF;
        bus.mem_req_i = 1'b1;
        tick;
        checks++; if (bus.ram_a_o !== 32'h3FFFFFFF) begin failures++; $display("FAIL lh_a0: got %0h expected 3fffffff", bus.ram_a_o); end
        tick;
        checks++; if (bus.ram_a_o !== 32'h40000000) begin failures++; $display("FAIL lh_a1: got %0h expected 40000000", bus.ram_a_o); end
        cyc = 0;
        for (int i = 2; i <= 12; i++) begin
            tick;
            if (bus.mem_done_o === 1'b1) begin cyc = i; break; end
        end
        checks++; if (cyc !== 3) begin failures++; $display("FAIL lh_latency: got %0d expected 3", cyc); end
        checks++; if (bus.mem_rdata_o !== 32'h00005AA5) begin failures++; $display("FAIL lh_data: got %0h expected 5aa5", bus.mem_rdata_o); end
        bus.mem_req_i = 1'b0;
        tick;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.if_flush_i = 1'b0;
        bus.mem_req_i = 1'b0; bus.mem_wr_i = 1'b0; bus.mem_size_i = 2'd0;
        bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
        test_reset();
        test_if_read();
        test_store_load();
        test_priority();
        test_flush();
        test_size3();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
